sram_like_responder: RTL
========================

SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning the word-index width of the backing RAM.
REQ-002 SHALL have parameter DEPTH, default 2, meaning the maximum outstanding accepted-but-unanswered transactions (2..4).
REQ-003 SHALL have parameter MAX_DELAY, default 3, meaning the maximum extra response-delay cycles (used only under RESP_DELAY_EN).
REQ-004 SHALL use one clock and asynchronous active-high reset, with ports in this order: clk  input  1  clock; reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have the port req  input  1  requester request valid.
REQ-006 SHALL have the port wr  input  1  1=write, 0=read.
REQ-007 SHALL have the port size  input  2  0=byte, 1=half, 2=word.
REQ-008 SHALL have the port wstrb  input  4  write byte enables.
REQ-009 SHALL have the port addr  input  32  byte address.
REQ-010 SHALL have the port wdata  input  32  write data.
REQ-011 SHALL have the port addr_ok  output  1  request accepted this cycle.
REQ-012 SHALL have the port data_ok  output  1  response valid this cycle.
REQ-013 SHALL have the port rdata  output  32  read data, qualified by data_ok.
REQ-014 SHALL have the port ram_en  output  1  RAM access enable.
REQ-015 SHALL have the port ram_we  output  4  RAM byte write enables.
REQ-016 SHALL have the port ram_addr  output  ADDR_W  RAM word index.
REQ-017 SHALL have the port ram_wdata  output  32  RAM write data.
REQ-018 SHALL have the port ram_rdata  input  32  RAM read data, valid one cycle after ram_en.

Function
REQ-019 SHALL drive addr_ok = req & (outstanding < DEPTH) combinationally; a handshake is req & addr_ok.
REQ-020 SHALL issue the RAM access in the handshake cycle: ram_en=1, ram_addr=addr[ADDR_W+1:2], ram_wdata=wdata, ram_we = wr ? wstrb : 4'b0.
REQ-021 SHALL capture ram_rdata (reads) or 32'b0 (writes) into the response FIFO in the cycle after the handshake.
REQ-022 SHALL return responses strictly in acceptance order, exactly one data_ok pulse per accepted transaction; the requester cannot stall data_ok.
REQ-023 SHALL run a head-of-FIFO FSM with states EMPTY, DELAY and READY.
REQ-024 SHALL make these FSM transitions: EMPTY->READY on entry with zero delay; EMPTY->DELAY on entry with nonzero delay; DELAY->READY when the delay counter reaches 0; READY->EMPTY or READY->DELAY on pop, depending on the next entry.
REQ-025 SHALL assert data_ok only in READY and pop the head in that same cycle.
REQ-026 SHALL, without delay, give minimum latency of data_ok exactly one cycle after the handshake cycle.
REQ-027 SHALL decrement the outstanding count on data_ok and increment it on handshake; both in one cycle leave it unchanged, and a handshake is accepted in that cycle even when at DEPTH before the pop.
REQ-028 SHALL keep addr_ok=0 while full; req held high is accepted on the first non-full cycle with unchanged fields.
REQ-029 SHALL perform no alignment or size checking; wstrb=4'b0 writes still complete with data_ok.
REQ-030 SHALL hold rdata at its last value when data_ok=0.

Reset
REQ-031 SHALL on reset, at any time including mid-transaction, drop all outstanding entries; FSM->EMPTY, count=0, data_ok=0, rdata=0, ram_en=0, ram_we=0.
REQ-032 SHALL keep addr_ok combinational and therefore 0 while req=0.
REQ-033 SHALL issue no response for transactions accepted before reset.

Configuration
REQ-034 SHALL, with RESP_DELAY_EN defined, load each new head entry's delay from an 8-bit LFSR (seed 8'hA5 at reset, stepped every cycle) modulo (MAX_DELAY+1), giving 0..MAX_DELAY extra cycles.
REQ-035 SHALL, with RESP_DELAY_EN undefined, fix the delay at 0 so DELAY is unreachable and no LFSR logic exists.

Structure
REQ-036 SHALL place the FSM state encoding, size encodings and the LFSR seed/polynomial constants in the shared package.
REQ-037 SHALL implement the response storage as sub-module resp_fifo, a synchronous FIFO of DEPTH x 32 with push/pop/empty/full flags.

Verification
REQ-038 SHALL pass single read: RAM word 5 = 32'h1c000000; req read addr 32'h14 -> addr_ok same cycle, ram_addr=5, data_ok next cycle, rdata=32'h1c000000.
REQ-039 SHALL pass back-to-back reads: req held 3 cycles at addrs 0,4,8 with DEPTH=2 and delay off -> all three accepted on consecutive cycles, data_ok on consecutive cycles, data in order.
REQ-040 SHALL pass full: RESP_DELAY_EN, MAX_DELAY=3, continuous req -> addr_ok=0 whenever outstanding=2, never more than 2 unanswered, no lost or duplicated data_ok.
REQ-041 SHALL pass write: wr=1, wstrb=4'b0011, addr 32'h8, wdata 32'hdeadbeef -> ram_we=4'b0011, ram_addr=2, data_ok next cycle with rdata=0.
REQ-042 SHALL pass reset mid-flight: reset asserted one cycle after a handshake -> no data_ok ever for that request, count=0, next req accepted immediately.

Source files
------------

// File: rtl/sram_like_responder_pkg.sv
// Shared types and constants for the SRAM-like responder: head-of-queue FSM
// encoding, access size encodings and the response-delay LFSR constants.
package sram_like_responder_pkg;

    typedef enum logic [1:0] {
        HEAD_EMPTY = 2'd0,
        HEAD_DELAY = 2'd1,
        HEAD_READY = 2'd2
    } head_state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } access_size_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Galois form of x^8 + x^6 + x^5 + x^4 + 1 (maximal length)
    localparam logic [7:0] LFSR_POLY = 8'hB8;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        logic [7:0] shifted;
        shifted = cur >> 1;
        lfsr_step = cur[0] ? (shifted ^ LFSR_POLY) : shifted;
    endfunction

endpackage

// File: rtl/sram_like_responder_fifo.sv
// resp_fifo: DEPTH x WIDTH synchronous response queue; the head word is
// visible on head_data whenever the queue is not empty.
module resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[rd_ptr];

    // Storage carries no reset; only the pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_like_responder.sv
// SRAM-like requester-side responder: accepts up to DEPTH outstanding requests,
// drives the RAM in the handshake cycle and returns responses in order.
// Optional build macro RESP_DELAY_EN adds LFSR-driven random response delay.
module sram_like_responder
    import sram_like_responder_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DEPTH     = 2,
    parameter int MAX_DELAY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [3:0]        wstrb,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int DLY_W = $clog2(MAX_DELAY + 1) + 1;

    head_state_t      state;
    head_state_t      state_next;
    logic [DLY_W-1:0] dly_cnt;
    logic [DLY_W-1:0] dly_cnt_next;
    logic [DLY_W-1:0] new_delay;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_next;
    logic             handshake;
    logic             pend_valid;
    logic             pend_wr;
    logic [31:0]      capture_data;
    logic [31:0]      fifo_head;
    logic [31:0]      head_data;
    logic [31:0]      rdata_q;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_push;
    logic             fifo_pop;
    logic             unused_inputs;

    // Size, byte offset and upper address bits are intentionally ignored.
    assign unused_inputs = ^{size, addr[31:ADDR_W+2], addr[1:0], fifo_full};

    // A pop in the same cycle frees a slot, so acceptance is allowed even at DEPTH.
    assign data_ok   = (state == HEAD_READY);
    assign addr_ok   = ~reset & req & ((outstanding < CNT_W'(DEPTH)) | data_ok);
    assign handshake = req & addr_ok;

    assign ram_en    = handshake;
    assign ram_we    = (handshake & wr) ? wstrb : 4'b0000;
    assign ram_addr  = addr[ADDR_W+1:2];
    assign ram_wdata = wdata;

    // The entry issued last cycle is still in the capture stage; when it is the
    // head (queue empty) it is answered straight from the RAM read port.
    assign capture_data = pend_wr ? 32'h0 : ram_rdata;
    assign head_data    = fifo_empty ? capture_data : fifo_head;
    assign fifo_pop     = data_ok & ~fifo_empty;
    assign fifo_push    = pend_valid & ~(data_ok & fifo_empty);
    assign rdata        = data_ok ? head_data : rdata_q;

    resp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_resp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (capture_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

`ifdef RESP_DELAY_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    assign new_delay = DLY_W'({24'h0, lfsr} % (MAX_DELAY + 1));
`else
    assign new_delay = '0;
`endif

    always_comb begin
        outstanding_next = outstanding;
        if (handshake && !data_ok) begin
            outstanding_next = outstanding + 1'b1;
        end else if (!handshake && data_ok) begin
            outstanding_next = outstanding - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
            pend_valid  <= 1'b0;
            pend_wr     <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            outstanding <= outstanding_next;
            pend_valid  <= handshake;
            pend_wr     <= wr;
            if (data_ok) begin
                rdata_q <= head_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= HEAD_EMPTY;
            dly_cnt <= '0;
        end else begin
            state   <= state_next;
            dly_cnt <= dly_cnt_next;
        end
    end

    // A new head takes its delay when it arrives, either into an empty queue
    // or as the successor of a popped head.
    always_comb begin
        state_next   = state;
        dly_cnt_next = dly_cnt;
        case (state)
            HEAD_EMPTY: begin
                if (handshake) begin
                    dly_cnt_next = new_delay;
                    state_next   = (new_delay == '0) ? HEAD_READY : HEAD_DELAY;
                end
            end
            HEAD_DELAY: begin
                if (dly_cnt <= DLY_W'(1)) begin
                    dly_cnt_next = '0;
                    state_next   = HEAD_READY;
                end else begin
                    dly_cnt_next = dly_cnt - 1'b1;
                end
            end
            HEAD_READY: begin
                if (outstanding_next != '0) begin
                    dly_cnt_next = new_delay;
                    state_next   = (new_delay == '0) ? HEAD_READY : HEAD_DELAY;
                end else begin
                    dly_cnt_next = '0;
                    state_next   = HEAD_EMPTY;
                end
            end
            default: begin
                dly_cnt_next = '0;
                state_next   = HEAD_EMPTY;
            end
        endcase
    end

endmodule
